// File: rtl/irq_grant_decoder.sv
// Purpose : turns an accepted 3-bit request index into a registered one-hot grant and holds it until the source acks or TIMEOUT expires.
// Latency : grant appears one cycle after the accept edge; done/timeout/bad_ack are registered pulses one cycle after the deciding edge.
// Backpr. : in_ready is high only in IDLE; offers made while busy are dropped, not queued. The fastest request-to-request spacing is 3 cycles.
// Ports   : clk, rst (async, active-high) | in_valid/in_idx/in_ready request handshake | ack[7:0] per-source acknowledge
//           grant[7:0] one-hot | done/timeout/bad_ack pulses | busy (not IDLE) | grant_cnt saturating count of accepted requests
module irq_grant_decoder #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       in_idx,
    output logic             in_ready,
    input  logic [7:0]       ack,
    output logic [7:0]       grant,
    output logic             done,
    output logic             timeout,
    output logic             bad_ack,
    output logic             busy,
    output logic [CNT_W-1:0] grant_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_timer;
    logic [2:0]       r_idx;
    logic [7:0]       r_grant;
    logic             r_done;
    logic             r_timeout;
    logic             r_bad_ack;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0]       w_mask;
    logic             w_hit;
    logic             w_other;
    logic             w_expired;

    // Compare against the captured index, never the live in_idx, so late
    // changes on the request bus cannot steer an open grant.
    assign w_mask    = 8'd1 << r_idx;
    assign w_hit     = ack[r_idx];
    assign w_other   = |(ack & ~w_mask);
    assign w_expired = (r_timer == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= 8'd0;
            r_idx     <= 3'd0;
            r_grant   <= 8'd0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_bad_ack <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_bad_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_idx   <= in_idx;
                        r_grant <= 8'd1 << in_idx;
                        r_timer <= 8'd0;
                        r_state <= S_GRANT;
                        if (!(&r_cnt)) begin
                            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_GRANT: begin
                    // A stray ack only flags; it never disturbs the grant or timer.
                    r_bad_ack <= w_other;
                    // Matching ack is checked first so it wins a tie with expiry.
                    if (w_hit) begin
                        r_grant <= 8'd0;
                        r_done  <= 1'b1;
                        r_state <= S_GAP;
                    end else if (w_expired) begin
                        r_grant   <= 8'd0;
                        r_timeout <= 1'b1;
                        r_state   <= S_GAP;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_grant <= 8'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign grant     = r_grant;
    assign done      = r_done;
    assign timeout   = r_timeout;
    assign bad_ack   = r_bad_ack;
    assign grant_cnt = r_cnt;

endmodule

// File: doc/irq_grant_decoder.md
IRQ_GRANT_DECODER -- requirements
Module: irq_grant_decoder

Interface
REQ-001 Parameter TIMEOUT, default 16: number of grant cycles allowed without a matching acknowledge (legal range 2..255).
REQ-002 Parameter CNT_W, default 8: width of the accepted-request counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  an encoded request index is offered.
REQ-006 in_idx  input  3  binary request index (7 = highest-priority source, matching the 8-to-3 priority encoder output format).
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 ack  input  8  per-source acknowledge from the serviced source.
REQ-009 grant  output  8  registered one-hot grant; bit n set = source n granted.
REQ-010 done  output  1  one-cycle pulse: grant closed by the correct acknowledge.
REQ-011 timeout  output  1  one-cycle pulse: grant closed because TIMEOUT expired.
REQ-012 bad_ack  output  1  one-cycle pulse: an ack bit other than the granted bit was seen during GRANT.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant_cnt  output  CNT_W  count of accepted requests, saturating at all-ones.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-016 in_ready SHALL be 1 in IDLE only, combinationally decoded from the state.
REQ-017 Handshake: in_valid=1 and in_ready=1 at a rising edge SHALL accept the request; in_idx is captured; next state GRANT.
REQ-018 One cycle after acceptance, grant SHALL equal 1 shifted left by the captured index; grant is exactly one-hot in GRANT and all-zero in IDLE and GAP.
REQ-019 in_valid while not in IDLE SHALL be ignored and not queued; in_idx changes after acceptance SHALL NOT affect grant.
REQ-020 In GRANT, a wait timer SHALL start at 0 on entry and increment each cycle in which the granted ack bit is 0.
REQ-021 In GRANT, if the ack bit at the granted index is 1 at an edge: grant clears, done pulses for that one cycle, next state GAP.
REQ-022 In GRANT, if the granted ack bit is 0 and the timer equals TIMEOUT-1: grant clears, timeout pulses for one cycle, next state GAP; the grant is therefore held for exactly TIMEOUT cycles.
REQ-023 A matching ack on the same edge as expiry SHALL win: done pulses and timeout does not.
REQ-024 In GRANT, any ack bit other than the granted bit SHALL pulse bad_ack for one cycle; it does not change state, grant or the timer, and it may coincide with done.
REQ-025 ack SHALL be ignored in IDLE and GAP; bad_ack is never asserted in those states.
REQ-026 GAP SHALL last exactly one cycle (in_ready=0, grant=0), then go to IDLE unconditionally.
REQ-027 grant_cnt SHALL increment by 1 on each accepted handshake and hold at 2^CNT_W-1 once reached.
REQ-028 done, timeout and bad_ack SHALL be registered outputs.
REQ-029 Minimum request-to-request spacing SHALL be three cycles: accept, at least one GRANT cycle, then GAP.

Reset
REQ-030 While rst=1, immediately and independent of clk: state=IDLE, grant=0, done=0, timeout=0, bad_ack=0, busy=0, timer=0, captured index=0, grant_cnt=0.
REQ-031 rst asserted in GRANT or GAP SHALL abort the grant at once with no done or timeout pulse; after rst falls, in_ready=1 at the next cycle.

Verification
REQ-032 Basic grant: accept in_idx=5; ack=8'h20 two cycles later -> grant=8'h20 for two cycles, then done pulse, grant=0, one GAP cycle, in_ready=1; grant_cnt=1.
REQ-033 Timeout: accept in_idx=0; no ack -> grant=8'h01 held exactly 16 cycles, timeout pulses once, done stays 0.
REQ-034 Wrong ack: accept in_idx=3 (grant=8'h08); ack=8'h10 for one cycle -> bad_ack pulses one cycle, grant stays 8'h08; then ack=8'h18 -> done and bad_ack pulse together.
REQ-035 Back-pressure and expiry tie: in_valid held high for 10 cycles with in_idx varying -> only IDLE-cycle offers accepted, grant follows the captured index only; a matching ack on the expiry cycle -> done=1, timeout=0.
REQ-036 Async reset: rst pulsed mid-GRANT between clock edges -> grant=0 and busy=0 before the next edge; no done or timeout pulse; grant_cnt=0.
REQ-037 Saturation: CNT_W=2, five accepted requests -> grant_cnt reads 1, 2, 3, 3, 3.
